// File: rtl/alu_operand_pipe.sv
// Registered ALU operand pre-processing stage: decodes the opcode into adder
// operands and buffers results in a main register plus one skid entry.

module alu_operand_decode #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] amod,
  output logic [WIDTH-1:0] bmod
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_comb begin
    amod = a;
    bmod = b;
    unique casez (op)
      3'b000: begin amod = '0;  bmod = a;  end
      3'b001: begin amod = ONE; bmod = ~a; end
      3'b010: begin amod = a;   bmod = b;  end
      3'b011: begin amod = ONE; bmod = a;  end
      default: begin amod = a;  bmod = b;  end
    endcase
  end
endmodule

module alu_operand_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] AMod,
  output logic [WIDTH-1:0] BMod,
  output logic [2:0]       out_op,
  output logic [1:0]       occupancy
);
  typedef struct packed {
    logic [WIDTH-1:0] amod;
    logic [WIDTH-1:0] bmod;
    logic [2:0]       op;
  } entry_t;

  logic [WIDTH-1:0] dec_amod, dec_bmod;
  entry_t           in_entry, main_q, skid_q;
  logic             main_vld, skid_full;
  logic             accept, main_free;

  alu_operand_decode #(.WIDTH(WIDTH)) u_dec (
    .a   (A),
    .b   (B),
    .op  (Op),
    .amod(dec_amod),
    .bmod(dec_bmod)
  );

  assign in_entry  = '{amod: dec_amod, bmod: dec_bmod, op: Op};
  // in_ready comes straight from the skid flag, so it never sees out_ready.
  assign in_ready  = ~skid_full;
  assign accept    = in_valid & in_ready & ~flush;
  assign main_free = ~main_vld | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld  <= 1'b0;
      skid_full <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      // payload registers keep their last values; only the valid state clears
      main_vld  <= 1'b0;
      skid_full <= 1'b0;
    end else if (main_free) begin
      if (skid_full) begin
        main_q   <= skid_q;
        main_vld <= 1'b1;
        if (accept) skid_q    <= in_entry;
        else        skid_full <= 1'b0;
      end else if (accept) begin
        main_q   <= in_entry;
        main_vld <= 1'b1;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (accept) begin
      skid_q    <= in_entry;
      skid_full <= 1'b1;
    end
  end

  assign out_valid = main_vld;
  assign AMod      = main_q.amod;
  assign BMod      = main_q.bmod;
  assign out_op    = main_q.op;
  assign occupancy = {1'b0, main_vld} + {1'b0, skid_full};
endmodule

// File: doc/alu_operand_pipe.md
Name: alu_operand_pipe

Overview:
Parametrised, registered successor to the ALU operand pre-processing stage. It decodes a 3-bit ALU opcode and produces the two adder operands (AMod, BMod) for any operand width. It adds a valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, a synchronous flush and an occupancy output. It sits between the operand/opcode source and the adder/logic unit.

Parameters:
WIDTH, 4, operand width in bits (legal range 2..64)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all buffered entries
in_valid  input  1  input transaction valid
in_ready  output  1  block can accept an input this cycle
A  input  WIDTH  operand A
B  input  WIDTH  operand B
Op  input  3  ALU opcode
out_valid  output  1  AMod/BMod/out_op valid
out_ready  input  1  downstream accepts the output this cycle
AMod  output  WIDTH  first adder operand
BMod  output  WIDTH  second adder operand
out_op  output  3  opcode travelling with the operands
occupancy  output  2  number of held entries (0..2)

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: out_valid=0, in_ready=1, occupancy=0, AMod=0, BMod=0, out_op=0, skid entry empty.
- Decode is combinational on the accepted input and is captured with it:
  - Op=000 (pass A): AMod=0, BMod=A.
  - Op=001 (negate A): AMod=1 (zero-extended to WIDTH), BMod=~A.
  - Op=010 (add): AMod=A, BMod=B.
  - Op=011 (increment A): AMod=1, BMod=A.
  - Op=1xx (logic ops): AMod=A, BMod=B.
- Arithmetic rules: no arithmetic is done in this block. The constant 1 is WIDTH bits with only the LSB set. ~A is a bitwise complement over all WIDTH bits.
- Handshakes:
  - Input is accepted when in_valid and in_ready are both 1.
  - Output is consumed when out_valid and out_ready are both 1.
  - out_valid must not drop, and AMod/BMod/out_op must not change, while out_valid=1 and out_ready=0.
- Storage: a main output register plus one skid register.
  - in_ready = !skid_full. It is a registered signal and does not depend combinationally on out_ready.
- Latency is 1 cycle: an input accepted in cycle N appears on the outputs in cycle N+1 when the main register is empty or being consumed. Throughput is 1 transaction per cycle.
- Per-cycle update, where "main free" = !out_valid || out_ready:
  - main free, skid full: main <- skid. If an input is accepted this cycle, skid <- input; otherwise skid is emptied.
  - main free, skid empty: main <- input if accepted, else out_valid <- 0.
  - main not free, input accepted: skid <- input (skid must have been empty, which is guaranteed by in_ready).
  - Otherwise: hold.
- Ordering is strictly FIFO. No transaction may be dropped or duplicated except by flush.
- occupancy = out_valid + skid_full, updated together with the registers.
- Flush:
  - Takes priority over all other events in its cycle.
  - Next cycle: out_valid=0, skid empty, occupancy=0, in_ready=1.
  - An input presented in the flush cycle is discarded.
  - AMod/BMod/out_op keep their last values. They are don't-care while out_valid=0.
- Simultaneous events:
  - With occupancy=2, out_ready=1 and in_ready=0 in the same cycle: skid moves to main, and in_ready becomes 1 next cycle.
  - With occupancy=1, out_ready=1 and an input accepted in the same cycle: main is replaced by the input, and occupancy stays 1.
- Reset asserted mid-operation clears all state immediately, independent of clk.

Test Plan:
- WIDTH=8, reset released, single transaction Op=001 A=0x05 -> one cycle later out_valid=1, AMod=0x01, BMod=0xFA, out_op=001, occupancy=1.
- Back-to-back stream with out_ready=1: Op=000 A=0x3C; Op=011 A=0x7F; Op=010 A=0x12 B=0x34; Op=101 A=0xAA B=0x55 -> outputs on consecutive cycles, in order: (0x00,0x3C), (0x01,0x7F), (0x12,0x34), (0xAA,0x55).
- Back-pressure: out_ready=0 while 3 inputs are offered -> first two accepted, occupancy=2, in_ready=0, third held at input. Then out_ready=1 -> all three delivered in order, and in_ready returns to 1 the cycle after the first consume.
- Flush with occupancy=2 and in_valid=1 in the same cycle -> next cycle out_valid=0, occupancy=0, in_ready=1, and the flush-cycle input never appears at the output.
- Asynchronous reset pulse between clock edges while out_valid=1 -> out_valid, occupancy, AMod and BMod go to 0 immediately. The first post-reset transaction (Op=010 A=0x01 B=0x02) yields (0x01,0x02).
- WIDTH=16 with Op=001 A=0x0000 -> AMod=0x0001, BMod=0xFFFF. Randomised in_valid/out_ready over 1000 transactions -> scoreboard shows no loss, no duplication and no reordering.
